alaw_encoder: RTL and testbench
===============================

Name: alaw_encoder

Overview:
- Streaming linear-to-A-law compressor; the inverse of the team's alaw_decoder.
- Accepts 13-bit linear samples and emits 8-bit codes with the same field layout the decoder consumes: bit 7 sign, bits 6:4 segment, bits 3:0 mantissa.
- No 0x55 even-bit inversion.
- Two-stage valid/ready pipeline; sits between the sample source (ADC/PCM front end) and the serial framer.

Parameters:
- INPUT_TWOS, 0: 0 means in_lin is sign-magnitude {sign, mag[11:0]} (decoder output format); 1 means in_lin is 13-bit two's complement.
- CNT_W, 16: width of the clip_count saturating counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  sample present on in_lin
- in_ready  output  1  encoder accepts the sample this cycle
- in_lin  input  13  linear sample, format per INPUT_TWOS
- out_valid  output  1  out_alaw holds a valid code
- out_ready  input  1  downstream accepts the code this cycle
- out_alaw  output  8  {sign, seg[2:0], mant[3:0]}
- clip_count  output  CNT_W  count of two's-complement inputs equal to -4096; saturates at all-ones
- clip_clr  input  1  synchronous clear of clip_count

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_alaw=8'h00, clip_count=0.
- Stage 1, sign/magnitude:
  - INPUT_TWOS=0: sign=in_lin[12], mag=in_lin[11:0].
  - INPUT_TWOS=1: sign=in_lin[12], mag = sign ? -in_lin : in_lin (13-bit negate).
  - Input -4096 (13'h1000) saturates to mag=12'hFFF and increments clip_count.
  - Stage 1 registers sign and mag.
- Stage 2, segment/mantissa from the stage-1 registers:
  - Find k = position of the leading one in mag[11:5]; seg = k-4, mant = mag[seg+3:seg].
  - If mag[11:5]==0: seg=0, mant=mag[4:1].
  - mag[0] and every bit below the mantissa are truncated (round toward zero).
  - Stage 2 registers {sign, seg, mant} into out_alaw.
- Worked values:
  - mag 12'hFFF gives seg 7, mant F.
  - mag 12'h020 gives seg 1, mant 0.
  - mag 12'h01F gives seg 0, mant F.
  - Sign-magnitude -0 (13'h1000 with INPUT_TWOS=0) encodes to 8'h80.
- Handshake:
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready, and it is allowed.
- Transfers:
  - An input transfer is in_valid & in_ready.
  - An output transfer is out_valid & out_ready.
  - out_alaw is held stable while out_valid & !out_ready.
  - Once out_valid rises it stays high until the transfer completes.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no backpressure.
  - One sample per cycle sustained.
  - No bubbles inserted when out_ready is held high.
- Backpressure: with out_ready low, the pipeline fills (2 samples) and in_ready drops. No sample is dropped or duplicated.
- clip_count:
  - Increments on the input-transfer cycle of a clipped sample.
  - If clip_clr and an increment coincide, clip_clr wins: the result is 0.
  - Saturates at all-ones.
  - Always 0 when INPUT_TWOS=0.
- Reset mid-operation clears both stages immediately. In-flight samples are discarded and no out_valid is produced for them.

Decomposition:
- Shared include file alaw_defs.vh, shared with alaw_decoder:
  - field widths: ALAW_W=8, LIN_W=13, MAG_W=12
  - field positions: SIGN_BIT=7, SEG_MSB=6, SEG_LSB=4, MANT_MSB=3
  - constant LIN_MIN_TWOS=13'h1000
- One combinational sub-module, alaw_segment_encoder: takes mag[11:0], returns seg[2:0] and mant[3:0]; used in stage 2.

Test Plan:
- Exhaustive round-trip, INPUT_TWOS=0, out_ready=1: all 256 codes → alaw_decoder → encoder → code must equal the original; out_valid exactly 2 cycles after each input transfer.
- Boundary encodes (sign-magnitude): 13'h0FFF→8'h7F, 13'h1FFF→8'hFF, 13'h0020→8'h10, 13'h001F→8'h0F, 13'h0000→8'h00, 13'h0001→8'h00.
- INPUT_TWOS=1, three samples:
  - -1 (13'h1FFF) → mag 1 → 8'h80.
  - -4096 → 8'hFF, clip_count=1.
  - +4095 → 8'h7F.
  - Then clip_clr together with another -4096 → clip_count=0.
- Backpressure:
  - Stream 10 samples with out_ready low for cycles 3-7.
  - in_ready must drop after 2 samples are buffered.
  - out_alaw must stay stable while stalled.
  - All 10 codes must arrive in order with no loss or duplication.
- Random valid/ready toggling, 10k samples, checked against the reference model.
- Reset asserted with 2 samples in flight: out_valid=0 and out_alaw=8'h00 immediately; no stale output after release.

Source files
------------

// File: rtl/alaw_encoder_pkg.sv
// Shared A-law field definitions for the encoder slice.
// Holds the code/linear widths, the code field positions and the
// two's-complement clip value, plus a helper that packs a code
// from its fields.
package alaw_encoder_pkg;

  localparam int ALAW_W   = 8;
  localparam int LIN_W    = 13;
  localparam int MAG_W    = 12;
  localparam int SEG_W    = 3;
  localparam int MANT_W   = 4;
  localparam int SIGN_BIT = 7;
  localparam int SEG_MSB  = 6;
  localparam int SEG_LSB  = 4;
  localparam int MANT_MSB = 3;

  // Most negative two's-complement input; it has no positive counterpart
  // in 12 magnitude bits and is clipped to full scale.
  localparam logic [LIN_W-1:0] LIN_MIN_TWOS = 13'h1000;

  // Assemble {sign, seg, mant} at the decoder's field positions.
  function automatic logic [ALAW_W-1:0] pack_code(
    input logic              sign,
    input logic [SEG_W-1:0]  seg,
    input logic [MANT_W-1:0] mant
  );
    logic [ALAW_W-1:0] code;
    code                   = {ALAW_W{1'b0}};
    code[SIGN_BIT]         = sign;
    code[SEG_MSB:SEG_LSB]  = seg;
    code[MANT_MSB:0]       = mant;
    return code;
  endfunction

endpackage

// File: rtl/alaw_encoder_segment.sv
// alaw_segment_encoder: combinational magnitude-to-segment/mantissa map.
// Ports:
//   mag  [11:0] in  : linear magnitude
//   seg  [2:0]  out : segment = (leading-one position in mag[11:5]) - 4, else 0
//   mant [3:0]  out : four bits just below the leading one (mag[4:1] in seg 0)
// Bits below the mantissa are truncated (round toward zero).
module alaw_segment_encoder
  import alaw_encoder_pkg::*;
(
  input  logic [MAG_W-1:0]  mag,
  output logic [SEG_W-1:0]  seg,
  output logic [MANT_W-1:0] mant
);

  logic [SEG_W-1:0] shamt_s;

  // Leading-one search over mag[11:5]; segment 0 covers everything below 32.
  always_comb begin
    seg = 3'd0;
    if (mag[11]) begin
      seg = 3'd7;
    end else if (mag[10]) begin
      seg = 3'd6;
    end else if (mag[9]) begin
      seg = 3'd5;
    end else if (mag[8]) begin
      seg = 3'd4;
    end else if (mag[7]) begin
      seg = 3'd3;
    end else if (mag[6]) begin
      seg = 3'd2;
    end else if (mag[5]) begin
      seg = 3'd1;
    end else begin
      seg = 3'd0;
    end
  end

  // Segments 0 and 1 share the same mantissa window mag[4:1].
  always_comb begin
    shamt_s = seg;
    if (seg == 3'd0) begin
      shamt_s = 3'd1;
    end else begin
      shamt_s = seg;
    end
    mant = MANT_W'(mag >> shamt_s);
  end

endmodule

// File: rtl/alaw_encoder.sv
// alaw_encoder: two-stage streaming linear-to-A-law compressor.
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset
//   in_valid/in_ready : input handshake, in_lin is the 13-bit sample
//   out_valid/out_ready : output handshake, out_alaw = {sign, seg, mant}
//   clip_count        : saturating count of clipped two's-complement inputs
//   clip_clr          : synchronous clear of clip_count (wins over increment)
// Parameters:
//   INPUT_TWOS : 0 = sign-magnitude input, 1 = two's-complement input
//   CNT_W      : clip_count width
module alaw_encoder
  import alaw_encoder_pkg::*;
#(
  parameter int INPUT_TWOS = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIN_W-1:0]  in_lin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALAW_W-1:0] out_alaw,
  output logic [CNT_W-1:0]  clip_count,
  input  logic              clip_clr
);

  logic              s1_valid_r;
  logic              s1_sign_r;
  logic [MAG_W-1:0]  s1_mag_r;
  logic              out_valid_r;
  logic [ALAW_W-1:0] out_alaw_r;
  logic [CNT_W-1:0]  clip_count_r;

  logic              s2_load_s;
  logic              s1_load_s;
  logic              in_xfer_s;
  logic              in_sign_s;
  logic [MAG_W-1:0]  in_mag_s;
  logic              clip_s;
  logic [SEG_W-1:0]  seg_s;
  logic [MANT_W-1:0] mant_s;

  // Each stage loads when it is empty or its contents move on this cycle.
  assign s2_load_s = ~out_valid_r | out_ready;
  assign s1_load_s = ~s1_valid_r | s2_load_s;
  assign in_xfer_s = in_valid & s1_load_s;

  // Sign/magnitude split of the incoming sample, with -4096 clipped to full scale.
  always_comb begin
    in_sign_s = in_lin[LIN_W-1];
    in_mag_s  = in_lin[MAG_W-1:0];
    clip_s    = 1'b0;
    if (INPUT_TWOS != 0) begin
      if (in_lin == LIN_MIN_TWOS) begin
        clip_s   = 1'b1;
        in_mag_s = {MAG_W{1'b1}};
      end else if (in_sign_s) begin
        in_mag_s = MAG_W'(-in_lin);
      end else begin
        in_mag_s = in_lin[MAG_W-1:0];
      end
    end else begin
      clip_s   = 1'b0;
      in_mag_s = in_lin[MAG_W-1:0];
    end
  end

  // Stage 1 register: sign and magnitude.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_mag_r   <= {MAG_W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r <= in_sign_s;
        s1_mag_r  <= in_mag_s;
      end
    end
  end

  alaw_segment_encoder u_seg (
    .mag  (s1_mag_r),
    .seg  (seg_s),
    .mant (mant_s)
  );

  // Stage 2 register: packed code; held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_alaw_r  <= 8'h00;
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_alaw_r <= pack_code(s1_sign_r, seg_s, mant_s);
      end
    end
  end

  // Clip counter: clear has priority, increments stop at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_count_r <= {CNT_W{1'b0}};
    end else if (clip_clr) begin
      clip_count_r <= {CNT_W{1'b0}};
    end else if (in_xfer_s & clip_s & ~(&clip_count_r)) begin
      clip_count_r <= clip_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // in_ready is combinational from out_ready so a full pipeline can
  // accept a new sample in the same cycle the output drains.
  assign in_ready   = s1_load_s;
  assign out_valid  = out_valid_r;
  assign out_alaw   = out_alaw_r;
  assign clip_count = clip_count_r;

endmodule

// File: tb/tb_alaw_encoder.sv
// Directed bench for alaw_encoder: one sign-magnitude instance (dut0) and
// one two's-complement instance with a 3-bit clip counter (dut1).
module tb_alaw_encoder;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, clip_clr0;
  logic [12:0] in_lin0;
  logic [7:0]  out_alaw0;
  logic [15:0] clip_count0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, clip_clr1;
  logic [12:0] in_lin1;
  logic [7:0]  out_alaw1;
  logic [2:0]  clip_count1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [12:0] in_q0[$];
  int          in_c0[$];
  logic [7:0]  out_q0[$];
  int          out_c0[$];
  logic [7:0]  out_q1[$];
  logic [12:0] stim_q[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  alaw_encoder #(.INPUT_TWOS(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_lin(in_lin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_alaw(out_alaw0), .clip_count(clip_count0), .clip_clr(clip_clr0)
  );

  alaw_encoder #(.INPUT_TWOS(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_lin(in_lin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_alaw(out_alaw1), .clip_count(clip_count1), .clip_clr(clip_clr1)
  );

  // Record transfers half a cycle before the edge that completes them.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (in_valid0 && in_ready0 && !reset) begin
      in_q0.push_back(in_lin0);
      in_c0.push_back(cyc);
    end
    if (out_valid0 && out_ready0 && !reset) begin
      out_q0.push_back(out_alaw0);
      out_c0.push_back(cyc);
    end
    if (out_valid1 && out_ready1 && !reset) out_q1.push_back(out_alaw1);
  end

  // Reference A-law decoder: code -> sign-magnitude linear sample.
  function automatic logic [12:0] dec(input logic [7:0] c);
    logic [11:0] m;
    if (c[6:4] == 3'd0) m = {7'd0, c[3:0], 1'b1};
    else m = 12'({1'b1, c[3:0], 1'b1}) << (c[6:4] - 3'd1);
    return {c[7], m};
  endfunction

  // Reference encoder for sign-magnitude samples.
  function automatic logic [7:0] enc_model(input logic [12:0] lin);
    int mag, p, seg, mant;
    mag = int'(lin[11:0]);
    if (mag < 32) begin
      seg  = 0;
      mant = (mag >> 1) & 15;
    end else begin
      p = 11;
      while (((mag >> p) & 1) == 0) p--;
      seg  = p - 4;
      mant = (mag >> seg) & 15;
    end
    return {lin[12], 3'(seg), 4'(mant)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    in_q0.delete(); in_c0.delete(); out_q0.delete(); out_c0.delete(); out_q1.delete();
  endtask

  task automatic run_stream0();
    int g;
    foreach (stim_q[i]) begin
      in_valid0 = 1'b1;
      in_lin0   = stim_q[i];
      g = 0;
      @(negedge clk);
      while (!in_ready0 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) begin checks++; failures++; $display("FAIL stream0_accept idx=%0d in_ready stuck low", i); end
      tick();
    end
    in_valid0 = 1'b0;
  endtask

  task automatic run_stream1();
    int g;
    foreach (stim_q[i]) begin
      in_valid1 = 1'b1;
      in_lin1   = stim_q[i];
      g = 0;
      @(negedge clk);
      while (!in_ready1 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) begin checks++; failures++; $display("FAIL stream1_accept idx=%0d in_ready stuck low", i); end
      tick();
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid0 got=%b exp=0", out_valid0); end
    checks++; if (out_alaw0 !== 8'h00) begin failures++; $display("FAIL reset_out_alaw0 got=%h exp=00", out_alaw0); end
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1 got=%b exp=0", out_valid1); end
    checks++; if (clip_count1 !== 3'd0) begin failures++; $display("FAIL reset_clip_count1 got=%0d exp=0", clip_count1); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready0 got=%b exp=1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_release_out_valid0 got=%b exp=0", out_valid0); end
  endtask

  task automatic test_boundary();
    logic [7:0] got;
    clear_q();
    stim_q = {13'h0FFF, 13'h1FFF, 13'h0020, 13'h001F, 13'h0000, 13'h0001, 13'h1000};
    exp_q  = {8'h7F, 8'hFF, 8'h10, 8'h0F, 8'h00, 8'h00, 8'h80};
    run_stream0();
    for (int g = 0; g < 20 && out_q0.size() < 7; g++) tick();
    checks++; if (out_q0.size() != 7) begin failures++; $display("FAIL boundary_count got=%0d exp=7", out_q0.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < out_q0.size()) ? out_q0[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL boundary_code in=%h got=%h exp=%h", stim_q[i], got, exp_q[i]); end
    end
    checks++; if (clip_count0 !== 16'd0) begin failures++; $display("FAIL sm_clip_count got=%0d exp=0", clip_count0); end
  endtask

  task automatic test_roundtrip();
    logic [7:0] got;
    int lat;
    clear_q();
    stim_q.delete();
    for (int c = 0; c < 256; c++) stim_q.push_back(dec(8'(c)));
    out_ready0 = 1'b1;
    run_stream0();
    for (int g = 0; g < 20 && out_q0.size() < 256; g++) tick();
    checks++; if (out_q0.size() != 256 || in_c0.size() != 256) begin failures++; $display("FAIL roundtrip_count got=%0d exp=256", out_q0.size()); end
    for (int i = 0; i < 256 && i < out_q0.size() && i < in_c0.size(); i++) begin
      got = out_q0[i];
      checks++; if (got !== 8'(i)) begin failures++; $display("FAIL roundtrip_code got=%h exp=%h", got, 8'(i)); end
      lat = out_c0[i] - in_c0[i];
      checks++; if (lat != 2) begin failures++; $display("FAIL roundtrip_latency code=%h got=%0d exp=2", 8'(i), lat); end
    end
    if (out_c0.size() == 256) begin
      checks++; if (out_c0[255] - out_c0[0] != 255) begin failures++; $display("FAIL roundtrip_throughput span=%0d exp=255", out_c0[255] - out_c0[0]); end
    end
  endtask

  task automatic test_twos();
    logic [7:0] got;
    clear_q();
    stim_q = {13'h1FFF, 13'h1000, 13'h0FFF, 13'h1FDF};
    exp_q  = {8'h80, 8'hFF, 8'h7F, 8'h90};
    run_stream1();
    for (int g = 0; g < 20 && out_q1.size() < 4; g++) tick();
    checks++; if (out_q1.size() != 4) begin failures++; $display("FAIL twos_count got=%0d exp=4", out_q1.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < out_q1.size()) ? out_q1[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL twos_code in=%h got=%h exp=%h", stim_q[i], got, exp_q[i]); end
    end
    checks++; if (clip_count1 !== 3'd1) begin failures++; $display("FAIL clip_count_one got=%0d exp=1", clip_count1); end
    // Clear coincides with a clipped transfer: clear wins.
    in_valid1 = 1'b1; in_lin1 = 13'h1000; clip_clr1 = 1'b1;
    @(negedge clk);
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL clip_clr_in_ready got=%b exp=1", in_ready1); end
    tick();
    in_valid1 = 1'b0; clip_clr1 = 1'b0;
    @(negedge clk);
    checks++; if (clip_count1 !== 3'd0) begin failures++; $display("FAIL clip_clr_wins got=%0d exp=0", clip_count1); end
    tick();
    // Nine clips into a 3-bit counter must stop at 7.
    stim_q.delete();
    for (int i = 0; i < 9; i++) stim_q.push_back(13'h1000);
    run_stream1();
    repeat (4) tick();
    checks++; if (clip_count1 !== 3'd7) begin failures++; $display("FAIL clip_saturate got=%0d exp=7", clip_count1); end
    clip_clr1 = 1'b1;
    tick();
    clip_clr1 = 1'b0;
    checks++; if (clip_count1 !== 3'd0) begin failures++; $display("FAIL clip_clr_alone got=%0d exp=0", clip_count1); end
  endtask

  task automatic test_backpressure();
    int sent;
    logic [7:0] held, got;
    clear_q();
    sent = 0;
    held = 8'h00;
    for (int c = 0; c < 60 && (sent < 10 || out_q0.size() < 10); c++) begin
      out_ready0 = !(c >= 3 && c <= 7);
      in_valid0  = (sent < 10);
      in_lin0    = dec(8'(17 * sent));
      @(negedge clk);
      if (c == 2) begin checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL bp_ready_before got=%b exp=1", in_ready0); end end
      if (c == 5) begin checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL bp_ready_drop got=%b exp=0", in_ready0); end end
      if (c == 3) begin
        held = out_alaw0;
        checks++; if (out_valid0 !== 1'b1 || held !== 8'h11) begin failures++; $display("FAIL bp_stall_head valid=%b got=%h exp=11", out_valid0, held); end
      end
      if (c >= 4 && c <= 7) begin
        checks++; if (out_valid0 !== 1'b1 || out_alaw0 !== held) begin failures++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h exp=%h", c, out_valid0, out_alaw0, held); end
      end
      if (in_valid0 && in_ready0) sent++;
      tick();
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    checks++; if (out_q0.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", out_q0.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < out_q0.size()) ? out_q0[i] : 8'hxx;
      checks++; if (got !== 8'(17 * i)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got, 8'(17 * i)); end
    end
  endtask

  task automatic test_random();
    int sent, n;
    logic pend, prev_stall;
    logic [7:0] prev_code, exp;
    n = 10000;
    clear_q();
    sent = 0; pend = 1'b0; prev_stall = 1'b0; prev_code = 8'h00;
    for (int c = 0; c < 40000 && (sent < n || out_q0.size() < n); c++) begin
      out_ready0 = ($urandom_range(0, 3) != 0);
      if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
        pend    = 1'b1;
        in_lin0 = 13'($urandom_range(0, 8191));
      end
      in_valid0 = pend;
      @(negedge clk);
      if (prev_stall) begin
        checks++; if (out_valid0 !== 1'b1 || out_alaw0 !== prev_code) begin failures++; $display("FAIL rand_hold valid=%b got=%h exp=%h", out_valid0, out_alaw0, prev_code); end
      end
      prev_stall = out_valid0 && !out_ready0;
      prev_code  = out_alaw0;
      if (in_valid0 && in_ready0) begin sent++; pend = 1'b0; end
      tick();
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    checks++; if (out_q0.size() != n || in_q0.size() != n) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", out_q0.size(), n); end
    for (int i = 0; i < n && i < out_q0.size() && i < in_q0.size(); i++) begin
      exp = enc_model(in_q0[i]);
      checks++; if (out_q0[i] !== exp) begin failures++; $display("FAIL rand_code idx=%0d in=%h got=%h exp=%h", i, in_q0[i], out_q0[i], exp); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_lin0    = dec(8'h7F);
    tick();
    in_lin0 = dec(8'h3C);
    tick();
    in_valid0 = 1'b0;
    tick();
    checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin failures++; $display("FAIL mid_full valid=%b ready=%b exp=1/0", out_valid0, in_ready0); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid0); end
    checks++; if (out_alaw0 !== 8'h00) begin failures++; $display("FAIL mid_reset_code got=%h exp=00", out_alaw0); end
    tick();
    reset      = 1'b0;
    out_ready0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, out_valid0); end
      tick();
    end
    checks++; if (out_q0.size() != 0) begin failures++; $display("FAIL mid_stale_count got=%0d exp=0", out_q0.size()); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid0 = 1'b0; in_lin0 = 13'h0000; out_ready0 = 1'b1; clip_clr0 = 1'b0;
    in_valid1 = 1'b0; in_lin1 = 13'h0000; out_ready1 = 1'b1; clip_clr1 = 1'b0;
    test_reset();
    test_boundary();
    test_roundtrip();
    test_twos();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
